// File: rtl/sobel_window_gen.sv
// sobel_window_gen
//   Streaming 3x3 window generator for the Sobel Gx/Gy MAC pair. Takes a
//   raster-order pixel stream, keeps the two previous rows in line buffers and
//   emits one 3x3 window per image pixel, with edge-replicate padding on all
//   four borders.
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   pix_in/pix_valid    input pixel stream (raster order)
//   pix_ready           input accepted this cycle when high together with pix_valid
//   win_out             {w00,w01,w02,w10,w11,w12,w20,w21,w22}, w00 in MSBs, row 0 on top
//   win_valid/win_ready output handshake; win_x/win_y give the window centre
//   frame_done          high during the handshake of the last window of a frame
module sobel_window_gen #(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int IMG_IN_W = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IMG_IN_W-1:0]        pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [9*IMG_IN_W-1:0]      win_out,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y,
  output logic                       frame_done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int DW = IMG_IN_W;

  // One window column: top, middle and bottom tap.
  typedef struct packed {
    logic [DW-1:0] t;
    logic [DW-1:0] m;
    logic [DW-1:0] b;
  } col_t;

  typedef enum logic [1:0] {FILL, RUN, EOL, FLUSH} state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x, x_nx;
  logic [YW-1:0] y, y_nx;
  logic          held, held_nx;   // EOL/FLUSH: final window already loaded, waiting for it to go
  logic          live;            // keeps pix_ready low while reset is asserted
  col_t          c0, c1, c0_nx, c1_nx;   // columns x-2 and x-1 relative to the input pixel

  logic [DW-1:0] top_buf [IMG_W];
  logic [DW-1:0] mid_buf [IMG_W];

  logic          in_xfer, out_xfer, out_free;
  logic          load;
  logic [9*DW-1:0] load_win;
  logic [XW-1:0] load_x;
  logic [YW-1:0] load_y;
  col_t          new_col, f_l, f_c, f_r;
  logic [XW-1:0] xl, xr;

  function automatic logic [9*DW-1:0] mk_win(input col_t l, input col_t c, input col_t r);
    return {l.t, c.t, r.t, l.m, c.m, r.m, l.b, c.b, r.b};
  endfunction

  assign out_free   = !win_valid | win_ready;
  assign out_xfer   = win_valid & win_ready;
  assign pix_ready  = live & ((state == FILL) | ((state == RUN) & out_free));
  assign in_xfer    = pix_valid & pix_ready;
  assign frame_done = out_xfer & (win_x == XW'(IMG_W-1)) & (win_y == YW'(IMG_H-1));

  // Column entering the window from the input side; on row 0 the top tap
  // replicates the middle row.
  always_comb begin
    new_col.m = mid_buf[x];
    new_col.t = (y == '0) ? mid_buf[x] : top_buf[x];
    new_col.b = pix_in;
  end

  // Flush columns read straight from the buffers; bottom row replicates middle.
  always_comb begin
    xl    = (x == '0) ? x : x - 1'b1;
    xr    = (x == XW'(IMG_W-1)) ? x : x + 1'b1;
    f_l.t = top_buf[xl]; f_l.m = mid_buf[xl]; f_l.b = mid_buf[xl];
    f_c.t = top_buf[x];  f_c.m = mid_buf[x];  f_c.b = mid_buf[x];
    f_r.t = top_buf[xr]; f_r.m = mid_buf[xr]; f_r.b = mid_buf[xr];
  end

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    held_nx  = held;
    c0_nx    = c0;
    c1_nx    = c1;
    load     = 1'b0;
    load_win = mk_win(c0, c1, c1);
    load_x   = x;
    load_y   = y;
    case (state)
      FILL: if (in_xfer) begin
        if (x == XW'(IMG_W-1)) begin
          x_nx     = '0;
          y_nx     = '0;
          state_nx = RUN;
        end else x_nx = x + 1'b1;
      end
      RUN: if (in_xfer) begin
        if (x == '0) begin
          // left pad: column -1 is a copy of column 0
          c0_nx = new_col;
          c1_nx = new_col;
        end else begin
          load     = 1'b1;
          load_win = mk_win(c0, c1, new_col);
          load_x   = x - 1'b1;
          c0_nx    = c1;
          c1_nx    = new_col;
        end
        if (x == XW'(IMG_W-1)) begin
          x_nx     = '0;
          held_nx  = 1'b0;
          state_nx = EOL;
        end else x_nx = x + 1'b1;
      end
      EOL: begin
        if (!held) begin
          if (out_free) begin
            load     = 1'b1;
            load_win = mk_win(c0, c1, c1);
            load_x   = XW'(IMG_W-1);
            held_nx  = 1'b1;
          end
        end else if (out_xfer) begin
          held_nx = 1'b0;
          if (y == YW'(IMG_H-2)) begin
            x_nx     = '0;
            state_nx = FLUSH;
          end else begin
            y_nx     = y + 1'b1;
            state_nx = RUN;
          end
        end
      end
      FLUSH: begin
        if (!held) begin
          if (out_free) begin
            load     = 1'b1;
            load_win = mk_win(f_l, f_c, f_r);
            load_x   = x;
            load_y   = YW'(IMG_H-1);
            if (x == XW'(IMG_W-1)) held_nx = 1'b1;
            else x_nx = x + 1'b1;
          end
        end else if (out_xfer) begin
          held_nx  = 1'b0;
          x_nx     = '0;
          y_nx     = '0;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      x     <= '0;
      y     <= '0;
      held  <= 1'b0;
      live  <= 1'b0;
      c0    <= '0;
      c1    <= '0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      held  <= held_nx;
      live  <= 1'b1;
      c0    <= c0_nx;
      c1    <= c1_nx;
    end
  end

  // Output register only advances when empty or being taken, so a stalled
  // window stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_out   <= '0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (out_free) begin
      win_valid <= load;
      if (load) begin
        win_out <= load_win;
        win_x   <= load_x;
        win_y   <= load_y;
      end
    end
  end

  // Line buffers, read-before-write at the input column.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      mid_buf[x] <= pix_in;
      if (state == RUN) top_buf[x] <= mid_buf[x];
    end
  end

endmodule
